// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port between the multicycle core (master) and memory (slave).
interface mips_multicycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core on one memory port; 3-5 cycles per instruction, FETCH/MEM hold while mem_ready=0.
// Optional j instruction enabled by defining MIPS_MULTICYCLE_JUMP_EN.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_multicycle_if.master    mem,
  output logic [31:0]          pc,
  output logic [31:0]          ula_result,
  output logic [3:0]           state,
  output logic                 trap
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    MEM    = 4'd3,
    WB     = 4'd4,
    TRAP   = 4'd5
  } state_t;

  state_t      state_q, state_nxt;
  logic [31:0] pc_q, ir, a_q, b_q, alu_out, mdr;
  logic        trap_q;
  logic [31:0] rf [NUM_REGS];

  logic [5:0]    opcode, funct;
  logic [31:0]   imm_sext;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx;
  logic          is_rtype, rtype_ok, supported;
  logic [31:0]   rd_a, rd_b, alu_res;
  logic [RW-1:0] wb_idx;
  logic [31:0]   wb_data;
  logic          unused_ir;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_idx   = ir[21 +: RW];
  assign rt_idx   = ir[16 +: RW];
  assign rd_idx   = ir[11 +: RW];
  assign unused_ir = ^ir;

  assign is_rtype = (opcode == OP_RTYPE);
  assign rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    supported = (is_rtype && rtype_ok) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                (opcode == OP_SW) || (opcode == OP_BEQ);
`ifdef MIPS_MULTICYCLE_JUMP_EN
    if (opcode == OP_J) supported = 1'b1;
`endif
  end

  // Register 0 reads as zero regardless of array contents.
  assign rd_a = (rs_idx == '0) ? 32'd0 : rf[rs_idx];
  assign rd_b = (rt_idx == '0) ? 32'd0 : rf[rt_idx];

  always_comb begin
    alu_res = a_q + imm_sext;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    wb_idx  = is_rtype ? rd_idx : rt_idx;
    wb_data = (opcode == OP_LW) ? mdr : alu_out;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      FETCH:  if (mem.mem_ready) state_nxt = DECODE;
      DECODE: state_nxt = supported ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OP_LW, OP_SW:      state_nxt = MEM;
          OP_RTYPE, OP_ADDI: state_nxt = WB;
          default:           state_nxt = FETCH;
        endcase
      end
      MEM:     if (mem.mem_ready) state_nxt = (opcode == OP_SW) ? FETCH : WB;
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      trap_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem.mem_ready) begin
            ir   <= mem.mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        DECODE: begin
          a_q     <= rd_a;
          b_q     <= rd_b;
          alu_out <= pc_q + (imm_sext << 2);
          if (!supported) trap_q <= 1'b1;
        end
        EXEC: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: alu_out <= alu_res;
            OP_BEQ: if (a_q == b_q) pc_q <= alu_out;
`ifdef MIPS_MULTICYCLE_JUMP_EN
            OP_J:   pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
`endif
            default: ;
          endcase
        end
        MEM: begin
          if (mem.mem_ready && (opcode == OP_LW)) mdr <= mem.mem_rdata;
        end
        WB: begin
          if (wb_idx != '0) rf[wb_idx] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  // Address/strobe/data come only from registers, so they hold steady through a stall.
  assign mem.mem_req   = !reset && ((state_q == FETCH) || (state_q == MEM));
  assign mem.mem_we    = (state_q == MEM) && (opcode == OP_SW);
  assign mem.mem_addr  = (state_q == MEM) ? alu_out : pc_q;
  assign mem.mem_wdata = b_q;

  assign pc         = pc_q;
  assign ula_result = alu_out;
  assign state      = state_q;
  assign trap       = trap_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench: program in a bench-owned memory, data accesses below 0x100 stall 2 cycles.
module tb_mips_multicycle;
  logic        clock;
  logic        reset;
  logic [31:0] pc, ula_result;
  logic [3:0]  state;
  logic        trap;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [31:0] mem [128];
  logic        ld_en = 1'b0;
  logic [6:0]  ld_idx = '0;
  logic [31:0] ld_dat = '0;
  logic [1:0]  stall_left;
  logic        data_addr;

  mips_multicycle_if bus ();

  mips_multicycle #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem        (bus),
    .pc         (pc),
    .ula_result (ula_result),
    .state      (state),
    .trap       (trap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign data_addr     = (bus.mem_addr >= 32'h4) && (bus.mem_addr < 32'h100);
  assign bus.mem_ready = !(data_addr && (stall_left != 2'd0));
  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  always @(posedge clock) begin
    if (ld_en)
      mem[ld_idx] <= ld_dat;
    else if (!reset && bus.mem_req && bus.mem_we && bus.mem_ready)
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
    if (reset)
      stall_left <= 2'd2;
    else if (bus.mem_req && data_addr)
      stall_left <= (stall_left == 2'd0) ? 2'd2 : stall_left - 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] dat);
    ld_en  = 1'b1;
    ld_idx = addr[8:2];
    ld_dat = dat;
    @(negedge clock);
    ld_en  = 1'b0;
  endtask

  // Count cycles until the core sits in FETCH with pc == tgt; gives up at 100.
  task automatic wait_fetch(input logic [31:0] tgt, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((state == 4'd0) && (pc == tgt)) && (n < 100));
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clock);
    poke(32'h100, 32'h2001_0005);  // addi $1,$0,5
    poke(32'h104, 32'h2002_FFFD);  // addi $2,$0,-3
    poke(32'h108, 32'h0022_1820);  // add  $3,$1,$2
    poke(32'h10C, 32'h0041_202A);  // slt  $4,$2,$1
    poke(32'h110, 32'hAC03_0080);  // sw   $3,0x80($0)
    poke(32'h114, 32'hAC04_0084);  // sw   $4,0x84($0)
    poke(32'h118, 32'hAC01_0008);  // sw   $1,8($0)
    poke(32'h11C, 32'h8C05_0008);  // lw   $5,8($0)
    poke(32'h120, 32'hAC05_0088);  // sw   $5,0x88($0)
    poke(32'h124, 32'h1022_0005);  // beq  $1,$2,5 (not taken)
    poke(32'h128, 32'h1000_FFB5);  // beq  $0,$0,-75 -> 0x0
    poke(32'h000, 32'h1021_FFFF);  // beq  $1,$1,-1 (self loop)
    poke(32'h008, 32'h0000_0000);

    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_alu", ula_result, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);

    reset = 1'b0;
    #1;
    chk("first_req", {31'd0, bus.mem_req}, 32'd1);
    chk("first_addr", bus.mem_addr, 32'h100);
    chk("first_we", {31'd0, bus.mem_we}, 32'd0);

    wait_fetch(32'h104, cyc);
    chk("addi_cycles", cyc, 32'd4);
    chk("pc_after_first", pc, 32'h104);
    begin
      int rest;
      wait_fetch(32'h110, rest);
      chk("alu_prog_cycles", cyc + rest, 32'd16);
    end

    wait_fetch(32'h114, cyc);
    chk("sw_stall_cycles", cyc, 32'd6);
    chk("add_result", mem[32], 32'd2);
    wait_fetch(32'h118, cyc);
    chk("slt_result", mem[33], 32'd1);

    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("sw_state", {28'd0, state}, 32'd3);
      chk("sw_addr_stable", bus.mem_addr, 32'h8);
      chk("sw_we_stable", {31'd0, bus.mem_we}, 32'd1);
      chk("sw_wdata_stable", bus.mem_wdata, 32'd5);
      chk("sw_ready", {31'd0, bus.mem_ready}, (i == 2) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    chk("after_sw_state", {28'd0, state}, 32'd0);
    chk("after_sw_pc", pc, 32'h11C);

    wait_fetch(32'h120, cyc);
    chk("lw_stall_cycles", cyc, 32'd7);
    wait_fetch(32'h124, cyc);
    chk("lw_result", mem[34], 32'd5);

    wait_fetch(32'h128, cyc);
    chk("beq_ne_cycles", cyc, 32'd3);
    wait_fetch(32'h0, cyc);
    chk("beq_far_cycles", cyc, 32'd3);
    wait_fetch(32'h0, cyc);
    chk("beq_self_cycles", cyc, 32'd3);
    chk("beq_self_pc", pc, 32'h0);

    reset = 1'b1;
    #1;
    chk("rst2_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clock);
    poke(32'h100, 32'h1000_FFBF);  // beq $0,$0,-65 -> 0x0
    poke(32'h000, 32'h0800_0040);  // j 0x100
    reset = 1'b0;
    wait_fetch(32'h0, cyc);
    chk("to_zero_cycles", cyc, 32'd3);
`ifdef MIPS_MULTICYCLE_JUMP_EN
    wait_fetch(32'h100, cyc);
    chk("j_cycles", cyc, 32'd3);
    chk("j_pc", pc, 32'h100);
    chk("j_trap", {31'd0, trap}, 32'd0);
`else
    repeat (2) @(negedge clock);
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_state", {28'd0, state}, 32'd5);
    chk("trap_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("trap_pc", pc, 32'h4);
    repeat (4) @(negedge clock);
    chk("trap_hold_pc", pc, 32'h4);
    chk("trap_hold_state", {28'd0, state}, 32'd5);
    chk("trap_hold_req", {31'd0, bus.mem_req}, 32'd0);
`endif

    reset = 1'b1;
    @(negedge clock);
    poke(32'h100, 32'h8C06_0008);  // lw $6,8($0)
    poke(32'h008, 32'h0000_0077);
    poke(32'h090, 32'hDEAD_BEEF);
    chk("rst3_trap", {31'd0, trap}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("lw_mid_state", {28'd0, state}, 32'd3);
    chk("lw_mid_ready", {31'd0, bus.mem_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clock);
    chk("mid_rst_req_hold", {31'd0, bus.mem_req}, 32'd0);
    poke(32'h100, 32'hAC06_0090);  // sw $6,0x90($0)
    poke(32'h104, 32'h1000_FFFF);  // beq $0,$0,-1
    chk("mid_rst_state", {28'd0, state}, 32'd0);
    chk("mid_rst_pc", pc, 32'h100);
    reset = 1'b0;
    wait_fetch(32'h104, cyc);
    chk("probe_cycles", cyc, 32'd6);
    chk("lw_abandoned", mem[36], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
